// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths, FSM state encoding and wave-type codes for the DDS sweep path
package dds_pkg;

    localparam int FW_W_DEF    = 32;
    localparam int PW_W_DEF    = 12;
    localparam int DWELL_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    localparam logic [1:0] WAVE_SINE     = 2'd0;
    localparam logic [1:0] WAVE_SQUARE   = 2'd1;
    localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] WAVE_SAWTOOTH = 2'd3;

endpackage

// File: rtl/dds_dwell_cnt.sv
// rtl/dds_dwell_cnt.sv - loadable down-counter; tc flags the last clock of a dwell while enabled
module dds_dwell_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-sweep sequencer feeding the DDS; SWEEP_TRIANGLE_EN adds up/down sweeps
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W    = FW_W_DEF,
    parameter int PW_W    = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic               continuous,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PW_W-1:0]    p_word_in,
    input  logic [1:0]         wave_in,
    output logic               dds_en,
    output logic [FW_W-1:0]    f_word,
    output logic [PW_W-1:0]    p_word,
    output logic [1:0]         wave_type,
    output logic               busy,
    output logic               step_strobe,
    output logic               done
);

    sweep_state_t state, state_nxt;

    logic [FW_W-1:0]    f_start_r, f_stop_r, f_step_r;
    logic [DWELL_W-1:0] dwell_r, dwell_m1;
    logic               cont_r;

    logic               accept, advance, tc, cnt_load;
    logic               degenerate, up_end;
    logic [FW_W:0]      sum_up;
    logic [FW_W-1:0]    up_word, step_word;

    logic [FW_W-1:0]    f_word_d;
    logic               strobe_d, busy_d, done_d;

`ifdef SWEEP_TRIANGLE_EN
    logic               dir_r, dir_nxt;
    logic [FW_W:0]      diff_dn;
    logic [FW_W-1:0]    down_word;
`endif

    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    assign accept   = (state == ST_IDLE) && start && !stop_req;
    assign cnt_load = accept || advance;

    dds_dwell_cnt #(.W(DWELL_W)) u_dwell (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .en       (state == ST_RUN),
        .load     (cnt_load),
        .load_val (accept ? dwell_m1 : dwell_r),
        .tc       (tc)
    );

    // Sums are one bit wider so a carry out of FW_W still reads as "past f_stop".
    assign sum_up     = {1'b0, f_word} + {1'b0, f_step_r};
    assign degenerate = (f_step_r == '0) || (f_start_r > f_stop_r);
    assign up_end     = degenerate || (f_word == f_stop_r);
    assign up_word    = (sum_up > {1'b0, f_stop_r}) ? f_stop_r : sum_up[FW_W-1:0];

`ifdef SWEEP_TRIANGLE_EN
    assign diff_dn   = {1'b0, f_word} - {1'b0, f_step_r};
    assign down_word = (diff_dn[FW_W] || (diff_dn[FW_W-1:0] < f_start_r)) ? f_start_r
                                                                          : diff_dn[FW_W-1:0];

    always_comb begin
        step_word = up_end ? f_start_r : up_word;
        dir_nxt   = dir_r;
        if (cont_r && !degenerate) begin
            if (!dir_r) begin
                if (f_word == f_stop_r) begin
                    dir_nxt   = 1'b1;
                    step_word = down_word;
                end else begin
                    step_word = up_word;
                end
            end else begin
                if (f_word == f_start_r) begin
                    dir_nxt   = 1'b0;
                    step_word = up_word;
                end else begin
                    step_word = down_word;
                end
            end
        end
    end
`else
    assign step_word = up_end ? f_start_r : up_word;
`endif

    // A stop request wins over a dwell end landing on the same cycle.
    assign advance = (state == ST_RUN) && !stop_req && tc && (cont_r || !up_end);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (tc && up_end && !cont_r) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        f_word_d = f_word;
        strobe_d = 1'b0;
        busy_d   = (state_nxt == ST_RUN);
        done_d   = (state_nxt == ST_DONE);
        if (accept) begin
            f_word_d = f_start;
            strobe_d = 1'b1;
        end else if (advance) begin
            f_word_d = step_word;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            f_start_r   <= '0;
            f_stop_r    <= '0;
            f_step_r    <= '0;
            dwell_r     <= '0;
            cont_r      <= 1'b0;
            f_word      <= '0;
            p_word      <= '0;
            wave_type   <= '0;
            busy        <= 1'b0;
            dds_en      <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept) begin
                f_start_r <= f_start;
                f_stop_r  <= f_stop;
                f_step_r  <= f_step;
                dwell_r   <= dwell_m1;
                cont_r    <= continuous;
                p_word    <= p_word_in;
                wave_type <= wave_in;
            end
            f_word      <= f_word_d;
            busy        <= busy_d;
            dds_en      <= busy_d;
            step_strobe <= strobe_d;
            done        <= done_d;
        end
    end

`ifdef SWEEP_TRIANGLE_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dir_r <= 1'b0;
        end else if (accept) begin
            dir_r <= 1'b0;
        end else if (advance) begin
            dir_r <= dir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed-vector bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic        stop_req = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [23:0] dwell = '0;
    logic [11:0] p_word_in = '0;
    logic [1:0]  wave_in = '0;
    logic        dds_en, busy, step_strobe, done;
    logic [31:0] f_word;
    logic [11:0] p_word;
    logic [1:0]  wave_type;

    int vectors = 0;
    int miscompares = 0;

    dds_sweep_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .stop_req    (stop_req),
        .continuous  (continuous),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .p_word_in   (p_word_in),
        .wave_in     (wave_in),
        .dds_en      (dds_en),
        .f_word      (f_word),
        .p_word      (p_word),
        .wave_type   (wave_type),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic program_sweep(input logic [31:0] fs, input logic [31:0] fe,
                                 input logic [31:0] st, input logic [23:0] dw,
                                 input logic cont);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(); tick();
        sys_rst = 1'b0;
        vectors++;
        if ({dds_en, busy, step_strobe, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=0000", {dds_en, busy, step_strobe, done});
        end
        vectors++;
        if ({f_word, p_word, wave_type} !== '0) begin
            miscompares++;
            $display("FAIL reset_words f_word=%0h p_word=%0h wave=%0d want 0", f_word, p_word, wave_type);
        end
    endtask

    task automatic test_single_basic();
        int strobes = 0;
        p_word_in = 12'h123; wave_in = 2'd2;
        program_sweep(32'd100, 32'd130, 32'd10, 24'd4, 1'b0);
        vectors++;
        if (p_word !== 12'h123 || wave_type !== 2'd2) begin
            miscompares++;
            $display("FAIL basic_pw got=%0h/%0d want=123/2", p_word, wave_type);
        end
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin p_word_in = 12'h777; wave_in = 2'd1; end
            strobes += int'(step_strobe);
            vectors++;
            if (f_word !== 32'(100 + 10 * (c / 4)) || step_strobe !== (c % 4 == 0) || busy !== 1'b1 || dds_en !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_cyc%0d f_word=%0d strobe=%b busy=%b want %0d/%b/1",
                         c, f_word, step_strobe, busy, 100 + 10 * (c / 4), c % 4 == 0);
            end
            tick();
        end
        vectors++;
        if (strobes != 4) begin
            miscompares++;
            $display("FAIL basic_strobes got=%0d want=4", strobes);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || dds_en !== 1'b0 || f_word !== 32'd130) begin
            miscompares++;
            $display("FAIL basic_done done=%b busy=%b en=%b f_word=%0d want 1/0/0/130", done, busy, dds_en, f_word);
        end
        vectors++;
        if (p_word !== 12'h123 || wave_type !== 2'd2) begin
            miscompares++;
            $display("FAIL basic_pw_hold got=%0h/%0d want=123/2", p_word, wave_type);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || dds_en !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle done=%b en=%b want 0/0", done, dds_en);
        end
    endtask

    task automatic test_clamp_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'd0; exp_w[1] = 32'd10; exp_w[2] = 32'd20; exp_w[3] = 32'd25;
        program_sweep(32'd0, 32'd25, 32'd10, 24'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (f_word !== exp_w[c] || step_strobe !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL clamp_cyc%0d f_word=%0d strobe=%b want %0d/1", c, f_word, step_strobe, exp_w[c]);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_done done=%b busy=%b want 1/0", done, busy);
        end
        tick();
        // first IDLE cycle after DONE: a new start must be taken
        program_sweep(32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'h20, 24'd1, 1'b0);
        vectors++;
        if (f_word !== 32'hFFFF_FFE0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_start f_word=%0h busy=%b want ffffffe0/1", f_word, busy);
        end
        tick();
        vectors++;
        if (f_word !== 32'hFFFF_FFF0 || step_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_clamp f_word=%0h strobe=%b want fffffff0/1", f_word, step_strobe);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || f_word !== 32'hFFFF_FFF0) begin
            miscompares++;
            $display("FAIL carry_done done=%b f_word=%0h want 1/fffffff0", done, f_word);
        end
        tick();
    endtask

    task automatic test_continuous_stop();
        logic [31:0] exp_w [6];
`ifdef SWEEP_TRIANGLE_EN
        exp_w[0] = 0; exp_w[1] = 10; exp_w[2] = 20; exp_w[3] = 10; exp_w[4] = 0; exp_w[5] = 10;
`else
        exp_w[0] = 0; exp_w[1] = 10; exp_w[2] = 20; exp_w[3] = 0; exp_w[4] = 10; exp_w[5] = 20;
`endif
        program_sweep(32'd0, 32'd20, 32'd10, 24'd2, 1'b1);
        for (int c = 0; c < 12; c++) begin
            start = (c == 4);
            f_start = (c == 4) ? 32'd77 : 32'd0;
            vectors++;
            if (f_word !== exp_w[c / 2] || step_strobe !== (c % 2 == 0) || busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL cont_cyc%0d f_word=%0d strobe=%b busy=%b done=%b want %0d/%b/1/0",
                         c, f_word, step_strobe, busy, done, exp_w[c / 2], c % 2 == 0);
            end
            stop_req = (c == 11);
            tick();
        end
        stop_req = 1'b0;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || dds_en !== 1'b0 || done !== 1'b0 || step_strobe !== 1'b0 || f_word !== exp_w[5]) begin
            miscompares++;
            $display("FAIL cont_stop busy=%b en=%b done=%b strobe=%b f_word=%0d want 0/0/0/0/%0d",
                     busy, dds_en, done, step_strobe, f_word, exp_w[5]);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_after_stop done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_start_stop_same();
        f_start = 32'd5; f_stop = 32'd9; f_step = 32'd1; dwell = 24'd1; continuous = 1'b0;
        start = 1'b1; stop_req = 1'b1;
        tick();
        start = 1'b0; stop_req = 1'b0;
        vectors++;
        if (busy !== 1'b0 || step_strobe !== 1'b0 || dds_en !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop busy=%b strobe=%b en=%b want 0/0/0", busy, step_strobe, dds_en);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop_2 busy=%b want 0", busy);
        end
    endtask

    task automatic test_degenerate();
        p_word_in = 12'h3A5; wave_in = 2'd3;
        program_sweep(32'd50, 32'd40, 32'd5, 24'd3, 1'b0);
        p_word_in = 12'h000; wave_in = 2'd0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (f_word !== 32'd50 || busy !== 1'b1 || p_word !== 12'h3A5 || wave_type !== 2'd3) begin
                miscompares++;
                $display("FAIL degen_cyc%0d f_word=%0d busy=%b pw=%0h wave=%0d want 50/1/3a5/3",
                         c, f_word, busy, p_word, wave_type);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || f_word !== 32'd50) begin
            miscompares++;
            $display("FAIL degen_done done=%b busy=%b f_word=%0d want 1/0/50", done, busy, f_word);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        p_word_in = 12'h0F0; wave_in = 2'd1;
        program_sweep(32'd1000, 32'd2000, 32'd100, 24'd2, 1'b1);
        tick(); tick(); tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        vectors++;
        if ({dds_en, busy, step_strobe, done} !== 4'b0000 || {f_word, p_word, wave_type} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid flags=%b f_word=%0d pw=%0h wave=%0d want all 0",
                     {dds_en, busy, step_strobe, done}, f_word, p_word, wave_type);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || step_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle busy=%b strobe=%b want 0/0", busy, step_strobe);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_basic();
        test_clamp_back_to_back();
        test_continuous_stop();
        test_start_stop_same();
        test_degenerate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer that sits directly upstream of the DDS `top` and drives its `dds_en`, `f_word`, `p_word` and `wave_type` inputs. On a start pulse it latches a sweep programme: start word, stop word, step and dwell. It then steps the frequency word through the range, holding each value for a fixed number of clocks, in single-shot or continuous mode. Phase word and wave type are latched per sweep and held constant, so the DDS sees glitch-free parameter changes on step boundaries only.

## Interface
- `FW_W`, 32: frequency word width; matches DDS `f_word`.
- `PW_W`, 12: phase word width; matches DDS `p_word`.
- `DWELL_W`, 24: dwell counter width.
- `sys_clk` in 1: system clock. Single clock domain.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: sweep start request, sampled each cycle.
- `stop_req` in 1: abort request, sampled each cycle.
- `continuous` in 1: 0 = single sweep, 1 = repeat until `stop_req`. Latched at start.
- `f_start` in FW_W: first frequency word.
- `f_stop` in FW_W: last frequency word.
- `f_step` in FW_W: increment per step.
- `dwell` in DWELL_W: clocks per step; 0 is treated as 1.
- `p_word_in` in PW_W: phase word for the sweep.
- `wave_in` in 2: wave type for the sweep.
- `dds_en` out 1: DDS enable.
- `f_word` out FW_W: frequency word to DDS.
- `p_word` out PW_W: phase word to DDS.
- `wave_type` out 2: wave type to DDS.
- `busy` out 1: sweep in progress.
- `step_strobe` out 1: one-cycle pulse in each cycle where `f_word` takes a new value.
- `done` out 1: one-cycle pulse when a single sweep completes.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; all outputs and latched registers 0.
- IDLE → RUN when `start`=1 and `stop_req`=0.
  - Latch `f_start`, `f_stop`, `f_step`, D=max(`dwell`,1), `continuous`, `p_word_in`, `wave_in`.
  - Input changes during RUN are ignored.
  - If `start` and `stop_req` are high together in IDLE, stay in IDLE.
- RUN: the dwell counter counts D cycles per word. At dwell end, compute next = `f_word` + `f_step` in FW_W+1 bits.
  - If `f_word` == `f_stop`, or `f_step`==0, or `f_start` > `f_stop`, the sweep is at its end point.
  - Else if next > `f_stop` (carry included), the next word is `f_stop`, clamped; `f_stop` is always visited.
  - Else the next word is next.
- End point, single mode: go to DONE.
- End point, continuous mode: reload `f_start` (sawtooth).
- DONE: lasts one cycle with `done`=1, then IDLE.
- `stop_req` in RUN → IDLE next cycle with no `done` pulse. Takes priority over a coinciding step.
- `start` while in RUN or DONE is ignored.
- Leaving RUN: `dds_en`, `busy` ← 0. `f_word`, `p_word`, `wave_type` hold their last values.
- Degenerate programmes (`f_step`=0 or `f_start`>`f_stop`): `f_start` is held for one dwell, then the end-point action applies.

## Timing
- `start` sampled at cycle N → at N+1: `busy`=`dds_en`=1, `f_word`=`f_start`, `p_word`/`wave_type` valid, `step_strobe`=1.
- Each word is held exactly D cycles. `step_strobe` is high in the first cycle of each word, including every continuous-mode reload.
- Last word of a single sweep: held D cycles, then one DONE cycle (`done`=1, `busy`=0, `dds_en`=0), then IDLE.
- A new `start` is accepted in the first IDLE cycle after DONE.
- `stop_req` at cycle M in RUN → `busy`=`dds_en`=0 at M+1.
- `sys_rst` mid-sweep → reset values on the next edge.
- All outputs are registered. No combinational path from input to output.

## Configuration
- `SWEEP_TRIANGLE_EN` defined: in continuous mode, reaching `f_stop` reverses direction instead of reloading `f_start`.
  - Down-steps subtract `f_step` and clamp at `f_start`. Reaching `f_start` reverses to up.
  - End-point words are not repeated at reversal; each is held one dwell.
  - Single mode is unchanged.
- Macro not defined: sawtooth only. No direction register or subtractor is synthesised.

## Structure
- Shared package `dds_pkg`:
  - State encoding constants (IDLE, RUN, DONE).
  - Wave type constants: 0 sine, 1 square, 2 triangle, 3 sawtooth.
  - Default widths.
- Sub-module `dds_dwell_cnt`: loadable down-counter with terminal-count pulse, DWELL_W wide.
- Next-word arithmetic and clamping stay in the top FSM.

## Test plan
- `f_start`=100, `f_stop`=130, `f_step`=10, `dwell`=4, single → `f_word` 100,110,120,130, each held 4 cycles; 4 `step_strobe` pulses; `done` one cycle after 130's dwell; `dds_en` 0 afterwards.
- `f_start`=0, `f_stop`=25, `f_step`=10, `dwell`=0 → words 0,10,20,25 (clamped), one cycle each; `done` at the 5th cycle after the first word.
- `f_stop`=0xFFFF_FFF0, `f_step`=0x20, starting at 0xFFFF_FFE0 → next word 0xFFFF_FFF0 (carry clamp), no wrap to a small value.
- Continuous, 0→20, step 10, `dwell`=2 → 0,10,20,0,10,…. With `SWEEP_TRIANGLE_EN`: 0,10,20,10,0,10,…. `stop_req` at an arbitrary cycle → `busy`=0 next cycle, no `done`.
- `start`+`stop_req` same cycle in IDLE → stays IDLE. `start` during RUN ignored. `sys_rst` mid-sweep → all outputs 0 next cycle.
- `f_start`=50 > `f_stop`=40, `dwell`=3 → `f_word`=50 for 3 cycles, then `done`. `p_word_in`/`wave_in` changed mid-sweep → outputs unchanged.
